// File: rtl/fwd_pkg.sv
// Shared constants and stage-record types for the RV32I forwarding/hazard unit.
package fwd_pkg;

  localparam int unsigned FWD_XLEN = 32;
  localparam int unsigned FWD_AW   = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_RET   = 2'b11;

  typedef struct packed {
    logic                v;
    logic [FWD_AW-1:0]   rd;
    logic                rw;
    logic                mr;
    logic [FWD_XLEN-1:0] result;
  } exmem_t;

  typedef struct packed {
    logic                v;
    logic [FWD_AW-1:0]   rd;
    logic                rw;
    logic [FWD_XLEN-1:0] data;
  } memwb_t;

  typedef struct packed {
    logic                v;
    logic [FWD_AW-1:0]   rd;
    logic [FWD_XLEN-1:0] data;
  } ret_t;

  function automatic logic writable(input logic v, input logic rw, input logic [FWD_AW-1:0] rd);
    return v & rw & (rd != '0);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// One forwarding channel: priority compare of a source register against the
// in-flight destinations and the 4:1 operand select.
module operand_fwd_mux
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned RF_BYPASS = 1
) (
  input  logic [AW-1:0]   i_rs,
  input  logic [XLEN-1:0] i_rf_data,
  input  logic            i_exmem_wr,
  input  logic            i_exmem_mr,
  input  logic [AW-1:0]   i_exmem_rd,
  input  logic [XLEN-1:0] i_exmem_data,
  input  logic            i_memwb_wr,
  input  logic [AW-1:0]   i_memwb_rd,
  input  logic [XLEN-1:0] i_memwb_data,
  input  logic            i_ret_wr,
  input  logic [AW-1:0]   i_ret_rd,
  input  logic [XLEN-1:0] i_ret_data,
  output logic [XLEN-1:0] o_operand,
  output logic [1:0]      o_sel
);

  logic [1:0] w_sel;

  // A load still in EX/MEM is never a source; the stall keeps that case from arising.
  always_comb begin
    w_sel = FWD_RF;
    if (i_rs != '0) begin
      if (i_exmem_wr && !i_exmem_mr && (i_exmem_rd == i_rs)) begin
        w_sel = FWD_EXMEM;
      end else if (i_memwb_wr && (i_memwb_rd == i_rs)) begin
        w_sel = FWD_MEMWB;
      end else if ((RF_BYPASS == 0) && i_ret_wr && (i_ret_rd == i_rs)) begin
        w_sel = FWD_RET;
      end
    end
  end

  always_comb begin
    o_operand = i_rf_data;
    case (w_sel)
      FWD_EXMEM: o_operand = i_exmem_data;
      FWD_MEMWB: o_operand = i_memwb_data;
      FWD_RET:   o_operand = i_ret_data;
      default:   o_operand = i_rf_data;
    endcase
  end

  assign o_sel = w_sel;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: owns the EX/MEM, MEM/WB (and optional
// retired-write) tracking registers, drives operand muxes and the RF write port.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned NSRC      = 2,
  parameter int unsigned RF_BYPASS = 1,
  parameter int unsigned CW        = 16,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_id_valid,
  input  logic [NSRC*AW-1:0]   i_id_rs,
  input  logic [NSRC-1:0]      i_id_uses_rs,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_regwrite,
  input  logic                 i_ex_memread,
  input  logic [AW-1:0]        i_ex_rd,
  input  logic [NSRC*AW-1:0]   i_ex_rs,
  input  logic [NSRC*XLEN-1:0] i_ex_rf_data,
  input  logic [XLEN-1:0]      i_ex_result,
  input  logic                 i_flush,
  input  logic [XLEN-1:0]      i_mem_load_data,
  output logic [NSRC*XLEN-1:0] o_ex_operand,
  output logic [NSRC*2-1:0]    o_fwd_sel,
  output logic                 o_stall,
  output logic                 o_wb_we,
  output logic [AW-1:0]        o_wb_rd,
  output logic [XLEN-1:0]      o_wb_data,
  output logic [CW-1:0]        o_stall_count
);

  exmem_t        r_exmem;
  memwb_t        r_memwb;
  ret_t          r_ret;
  logic [CW-1:0] r_stall_count;

  logic w_exmem_wr, w_memwb_wr, w_ret_wr, w_id_hit, w_stall;

  assign w_exmem_wr = writable(r_exmem.v, r_exmem.rw, r_exmem.rd);
  assign w_memwb_wr = writable(r_memwb.v, r_memwb.rw, r_memwb.rd);
  assign w_ret_wr   = r_ret.v & (r_ret.rd != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      r_exmem.v      <= i_ex_valid & ~i_flush;
      r_exmem.rd     <= i_ex_rd;
      r_exmem.rw     <= i_ex_regwrite;
      r_exmem.mr     <= i_ex_memread;
      r_exmem.result <= i_ex_result;
      r_memwb.v      <= r_exmem.v;
      r_memwb.rd     <= r_exmem.rd;
      r_memwb.rw     <= r_exmem.rw;
      r_memwb.data   <= r_exmem.mr ? i_mem_load_data : r_exmem.result;
    end
  end

  // Retired-write stage covers a register bank whose read misses a same-cycle write.
  if (RF_BYPASS == 0) begin : g_ret
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_ret <= '0;
      end else begin
        r_ret.v    <= w_memwb_wr;
        r_ret.rd   <= r_memwb.rd;
        r_ret.data <= r_memwb.data;
      end
    end
  end else begin : g_no_ret
    assign r_ret = '0;
  end

  always_comb begin
    w_id_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (i_id_uses_rs[i] && (i_id_rs[i*AW +: AW] == i_ex_rd)) w_id_hit = 1'b1;
    end
  end

  assign w_stall = i_id_valid & i_ex_valid & i_ex_memread & ~i_flush & (i_ex_rd != '0) & w_id_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_ch
    operand_fwd_mux #(
      .XLEN      (XLEN),
      .AW        (AW),
      .RF_BYPASS (RF_BYPASS)
    ) u_mux (
      .i_rs         (i_ex_rs[g*AW +: AW]),
      .i_rf_data    (i_ex_rf_data[g*XLEN +: XLEN]),
      .i_exmem_wr   (w_exmem_wr),
      .i_exmem_mr   (r_exmem.mr),
      .i_exmem_rd   (r_exmem.rd),
      .i_exmem_data (r_exmem.result),
      .i_memwb_wr   (w_memwb_wr),
      .i_memwb_rd   (r_memwb.rd),
      .i_memwb_data (r_memwb.data),
      .i_ret_wr     (w_ret_wr),
      .i_ret_rd     (r_ret.rd),
      .i_ret_data   (r_ret.data),
      .o_operand    (o_ex_operand[g*XLEN +: XLEN]),
      .o_sel        (o_fwd_sel[g*2 +: 2])
    );
  end

  assign o_stall       = w_stall;
  assign o_wb_we       = w_memwb_wr;
  assign o_wb_rd       = r_memwb.rd;
  assign o_wb_data     = r_memwb.data;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: a write-before-read build (byp) and a retired-write build (nob)
// share one stimulus stream; expected values are hand-computed per step.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_uses_rs;
  logic        ex_valid, ex_regwrite, ex_memread, flush;
  logic [4:0]  ex_rd;
  logic [9:0]  ex_rs;
  logic [63:0] ex_rf_data;
  logic [31:0] ex_result, mem_load_data;

  logic [63:0] op_b, op_n;
  logic [3:0]  sel_b, sel_n;
  logic        stall_b, stall_n, we_b, we_n;
  logic [4:0]  wrd_b, wrd_n;
  logic [31:0] wdata_b, wdata_n;
  logic [15:0] cnt_b, cnt_n;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.RF_BYPASS(1)) u_byp (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs),
    .i_id_uses_rs(id_uses_rs), .i_ex_valid(ex_valid), .i_ex_regwrite(ex_regwrite),
    .i_ex_memread(ex_memread), .i_ex_rd(ex_rd), .i_ex_rs(ex_rs), .i_ex_rf_data(ex_rf_data),
    .i_ex_result(ex_result), .i_flush(flush), .i_mem_load_data(mem_load_data),
    .o_ex_operand(op_b), .o_fwd_sel(sel_b), .o_stall(stall_b), .o_wb_we(we_b),
    .o_wb_rd(wrd_b), .o_wb_data(wdata_b), .o_stall_count(cnt_b)
  );

  fwd_hazard_unit #(.RF_BYPASS(0)) u_nob (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs),
    .i_id_uses_rs(id_uses_rs), .i_ex_valid(ex_valid), .i_ex_regwrite(ex_regwrite),
    .i_ex_memread(ex_memread), .i_ex_rd(ex_rd), .i_ex_rs(ex_rs), .i_ex_rf_data(ex_rf_data),
    .i_ex_result(ex_result), .i_flush(flush), .i_mem_load_data(mem_load_data),
    .o_ex_operand(op_n), .o_fwd_sel(sel_n), .o_stall(stall_n), .o_wb_we(we_n),
    .o_wb_rd(wrd_n), .o_wb_data(wdata_n), .o_stall_count(cnt_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel 0 is the low slice of every packed bus.
  task automatic set_ex(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [31:0] rf0, input logic [31:0] rf1,
                        input logic [31:0] res);
    ex_valid    = v;
    ex_regwrite = rw;
    ex_memread  = mr;
    ex_rd       = rd;
    ex_rs       = {rs1, rs0};
    ex_rf_data  = {rf1, rf0};
    ex_result   = res;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs0, input logic [1:0] uses);
    id_valid   = v;
    id_rs      = {5'd0, rs0};
    id_uses_rs = uses;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    mem_load_data = '0;
    set_id(0, 0, 2'b00);
    set_ex(0, 0, 0, 0, 0, 0, 32'd50, 32'd100, 0);
    repeat (3) tick();
    check("rst_wb_we", we_b, 0);
    check("rst_wb_rd", wrd_b, 0);
    check("rst_wb_data", wdata_b, 0);
    check("rst_stall", stall_b, 0);
    check("rst_count", cnt_n, 0);
    check("rst_sel", {sel_n, sel_b}, 0);
    check("rst_operand", op_b, {32'd100, 32'd50});
    rst_n = 1'b1;
    tick();
    check("post_rst_operand", op_n, {32'd100, 32'd50});
    check("post_rst_sel", sel_n, 0);

    // A: add x3 = 150
    set_ex(1, 1, 0, 3, 0, 0, 0, 0, 32'd150);
    tick();
    // B: add x4 = 400, reads x3 (ch0) and x1 (ch1)
    set_ex(1, 1, 0, 4, 3, 1, 0, 32'd100, 32'd400);
    #1;
    check("exmem_sel", sel_b, 4'b0010);
    check("exmem_operand", op_b, {32'd100, 32'd150});
    tick();
    // C: reads x3 (MEM/WB) and x4 (EX/MEM)
    set_ex(1, 0, 0, 0, 3, 4, 0, 0, 0);
    #1;
    check("memwb_sel", sel_b, 4'b1001);
    check("memwb_operand", op_b, {32'd400, 32'd150});
    check("wb_we_x3", we_b, 1);
    check("wb_rd_x3", wrd_b, 3);
    check("wb_data_x3", wdata_b, 32'd150);
    tick();
    // D: x3 three cycles old, rf stale
    set_ex(0, 0, 0, 0, 3, 4, 0, 0, 0);
    #1;
    check("byp_no_ret_sel", sel_b, 4'b0100);
    check("byp_no_ret_operand", op_b, {32'd400, 32'd0});
    check("ret_sel", sel_n, 4'b0111);
    check("ret_operand", op_n, {32'd400, 32'd150});
    tick();

    // Priority: x3 = 150 then x3 = 250
    set_ex(1, 1, 0, 3, 0, 0, 0, 0, 32'd150);
    tick();
    set_ex(1, 1, 0, 3, 0, 0, 0, 0, 32'd250);
    tick();
    set_ex(1, 0, 0, 0, 3, 0, 32'd7, 0, 0);
    #1;
    check("prio_sel", sel_b, 4'b0010);
    check("prio_operand", op_b[31:0], 32'd250);
    tick();

    // Load-use: lw x5 in EX, ID reads x5
    set_ex(1, 1, 1, 5, 0, 0, 0, 0, 32'h1000);
    set_id(1, 5, 2'b01);
    #1;
    check("lu_stall", stall_b, 1);
    check("lu_stall_nob", stall_n, 1);
    tick();
    set_ex(0, 0, 0, 0, 5, 0, 0, 0, 0);
    mem_load_data = 32'hDEAD_BEEF;
    #1;
    check("lu_stall_once", stall_b, 0);
    check("lu_count", cnt_b, 1);
    check("load_in_exmem_sel", sel_b, 4'b0000);
    tick();
    set_id(0, 0, 2'b00);
    set_ex(1, 0, 0, 0, 5, 0, 0, 0, 0);
    mem_load_data = '0;
    #1;
    check("load_fwd_sel", sel_b[1:0], 2'b01);
    check("load_fwd_operand", op_b[31:0], 32'hDEAD_BEEF);
    check("load_wb", {we_b, wrd_b, wdata_b}, {1'b1, 5'd5, 32'hDEAD_BEEF});
    tick();

    // Flush beats load-use and kills capture
    set_ex(1, 1, 1, 5, 0, 0, 0, 0, 32'h1000);
    set_id(1, 5, 2'b01);
    flush = 1'b1;
    #1;
    check("flush_stall", stall_b, 0);
    tick();
    flush = 1'b0;
    set_id(0, 0, 2'b00);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_load_data = 32'h1234;
    #1;
    check("flush_count", cnt_b, 1);
    tick();
    set_ex(0, 0, 0, 0, 5, 0, 32'd3, 0, 0);
    mem_load_data = '0;
    #1;
    check("flush_no_fwd", {sel_b[1:0], op_b[31:0]}, {2'b00, 32'd3});
    check("flush_wb_we", we_b, 0);
    tick();

    // x0: lw x0 never stalls, add x0 never forwards or writes back
    set_ex(1, 1, 1, 0, 0, 0, 0, 0, 0);
    set_id(1, 0, 2'b01);
    #1;
    check("x0_stall", stall_b, 0);
    tick();
    set_id(0, 0, 2'b00);
    set_ex(1, 1, 0, 0, 0, 0, 0, 0, 32'd99);
    tick();
    set_ex(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("x0_sel", {sel_n, sel_b}, 0);
    check("x0_operand", op_b, 0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("x0_wb_we", we_b, 0);
    tick();

    // add x7 = 42 reaches the write port two cycles later
    set_ex(1, 1, 0, 7, 0, 0, 0, 0, 32'd42);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("wb_x7", {we_b, wrd_b, wdata_b}, {1'b1, 5'd7, 32'd42});
    check("wb_x7_nob", {we_n, wrd_n, wdata_n}, {1'b1, 5'd7, 32'd42});

    // Saturation: hold the load-use condition well past 2^16 cycles
    set_ex(1, 1, 1, 5, 0, 0, 0, 0, 0);
    set_id(1, 5, 2'b01);
    repeat (65540) @(posedge clk);
    #1;
    check("sat_count", cnt_b, 16'hFFFF);
    check("sat_count_nob", cnt_n, 16'hFFFF);
    tick();
    check("sat_hold", cnt_b, 16'hFFFF);
    check("sat_stall", stall_b, 1);

    // Mid-stream reset discards x3 in flight
    set_id(0, 0, 2'b00);
    set_ex(1, 1, 0, 3, 0, 0, 0, 0, 32'd150);
    tick();
    set_ex(1, 1, 0, 8, 0, 0, 0, 0, 32'd1);
    tick();
    check("pre_rst_wb_we", we_b, 1);
    set_ex(0, 0, 0, 0, 3, 0, 32'd5, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wb_we", {we_n, we_b}, 0);
    check("mid_rst_count", cnt_b, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_mid_rst_sel", {sel_n, sel_b}, 0);
    check("post_mid_rst_operand", op_n[31:0], 32'd5);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
